// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_seq_pkg;

  localparam logic [5:0] OP_FRLD = 6'b000110;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADD2 = 6'b011101;
  localparam logic [5:0] OP_SUB  = 6'b100001;
  localparam logic [5:0] OP_MUL  = 6'b100010;
  localparam logic [5:0] OP_DIV  = 6'b100011;
  localparam logic [5:0] OP_MOD  = 6'b100101;
  localparam logic [5:0] OP_INC  = 6'b100100;
  localparam logic [5:0] OP_CMP  = 6'b010110;
  localparam logic [5:0] OP_AND  = 6'b010010;
  localparam logic [5:0] OP_OR   = 6'b010011;
  localparam logic [5:0] OP_XOR  = 6'b010100;
  localparam logic [5:0] OP_NOT  = 6'b010101;
  localparam logic [5:0] OP_SHF  = 6'b010000;

  localparam int unsigned FLAG_GT = 15;
  localparam int unsigned FLAG_LT = 14;
  localparam int unsigned FLAG_EQ = 13;
  localparam int unsigned FLAG_Z  = 12;
  localparam int unsigned FLAG_C  = 11;
  localparam int unsigned FLAG_OV = 10;
  localparam int unsigned FLAG_DZ = 9;
  localparam int unsigned FLAG_UF = 6;

  typedef enum logic [1:0] {StIdle, StExec, StDiv, StDone} alu_state_e;

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_param_div.sv
// Restoring unsigned divider: one quotient bit per cycle, valid pulses WIDTH cycles after load.
module alu_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             wire_clock,
  input  logic             wire_reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q, valid_q;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Partial remainder is always below the divisor, so the trial value fits in WIDTH+1 bits.
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign ge    = trial >= {1'b0, dvs_q};
  assign diff  = trial[WIDTH-1:0] - dvs_q;

  always_ff @(posedge wire_clock or posedge wire_reset) begin
    if (wire_reset) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (load) begin
        quo_q <= dividend;
        rem_q <= '0;
        dvs_q <= divisor;
        cnt_q <= CW'(WIDTH);
        run_q <= 1'b1;
      end else if (run_q) begin
        quo_q <= {quo_q[WIDTH-2:0], ge};
        rem_q <= ge ? diff : trial[WIDTH-1:0];
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q   <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign valid     = valid_q;

endmodule

// File: rtl/alu_seq_param.sv
// Handshaked multi-cycle ALU: single-cycle execute for most ops, iterative divide for div/mod.
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             wire_clock,
  input  logic             wire_reset,
  input  logic             start,
  input  logic [5:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_carry,
  input  logic [2:0]       shift_mode,
  input  logic             dec,
  input  logic [15:0]      fr_in,
  output logic [WIDTH-1:0] result,
  output logic [15:0]      fr_out,
  output logic             busy,
  output logic             done
);

  alu_state_e       state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             uc_q, uc_d, dec_q, dec_d;
  logic [2:0]       sm_q, sm_d;
  logic [15:0]      fr_q, fr_d, fr_out_q, fr_out_d;
  logic             div_load, div_valid;
  logic [WIDTH-1:0] div_quo, div_rem;

  logic               cin;
  logic [WIDTH:0]     sum, a_cin;
  logic [2*WIDTH-1:0] prod;
  logic [SHW-1:0]     n;
  logic [SHW:0]       n_inv;
  logic [WIDTH-1:0]   rotl, rotr;

  assign cin   = uc_q & fr_q[FLAG_C];
  assign sum   = {1'b0, a_q} + {1'b0, b_q} + (WIDTH + 1)'(cin);
  assign a_cin = {1'b0, a_q} + (WIDTH + 1)'(cin);
  assign prod  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign n     = b_q[SHW-1:0];
  assign n_inv = (SHW + 1)'(WIDTH) - {1'b0, n};
  // A shift by WIDTH yields zero, so n=0 degenerates cleanly to a.
  assign rotl  = (a_q << n) | (a_q >> n_inv);
  assign rotr  = (a_q >> n) | (a_q << n_inv);

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .wire_clock (wire_clock),
    .wire_reset (wire_reset),
    .load       (div_load),
    .dividend   (a),
    .divisor    (b),
    .quotient   (div_quo),
    .remainder  (div_rem),
    .valid      (div_valid)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    uc_d     = uc_q;
    dec_d    = dec_q;
    sm_d     = sm_q;
    fr_d     = fr_q;
    result_d = result_q;
    fr_out_d = fr_out_q;
    div_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = op_code;
          a_d   = a;
          b_d   = b;
          uc_d  = use_carry;
          dec_d = dec;
          sm_d  = shift_mode;
          fr_d  = fr_in;
          if (is_div_op(op_code) && (b != '0)) begin
            div_load = 1'b1;
            state_d  = StDiv;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        fr_out_d = fr_q;
        state_d  = StDone;
        case (op_q)
          OP_ADD, OP_ADD2: begin
            result_d         = sum[WIDTH-1:0];
            fr_out_d[FLAG_C] = sum[WIDTH];
            fr_out_d[FLAG_Z] = (sum[WIDTH-1:0] == '0);
          end
          OP_SUB: begin
            if ({1'b0, b_q} > a_cin) begin
              result_d          = '0;
              fr_out_d[FLAG_UF] = 1'b1;
              fr_out_d[FLAG_Z]  = 1'b1;
            end else begin
              result_d          = a_q - b_q + WIDTH'(cin);
              fr_out_d[FLAG_UF] = 1'b0;
              fr_out_d[FLAG_Z]  = ((a_q - b_q + WIDTH'(cin)) == '0);
            end
          end
          OP_MUL: begin
            result_d          = prod[WIDTH-1:0];
            fr_out_d[FLAG_OV] = (prod[2*WIDTH-1:WIDTH] != '0);
            fr_out_d[FLAG_Z]  = (prod[WIDTH-1:0] == '0);
          end
          OP_DIV, OP_MOD: fr_out_d[FLAG_DZ] = 1'b1;  // only reached with b == 0
          OP_INC: result_d = dec_q ? a_q - WIDTH'(1) : a_q + WIDTH'(1);
          OP_CMP: begin
            if (a_q > b_q)      fr_out_d[15:13] = 3'b100;
            else if (a_q < b_q) fr_out_d[15:13] = 3'b010;
            else                fr_out_d[15:13] = 3'b001;
          end
          OP_AND: begin
            result_d         = a_q & b_q;
            fr_out_d[FLAG_Z] = ((a_q & b_q) == '0);
          end
          OP_OR: begin
            result_d         = a_q | b_q;
            fr_out_d[FLAG_Z] = ((a_q | b_q) == '0);
          end
          OP_XOR: begin
            result_d         = a_q ^ b_q;
            fr_out_d[FLAG_Z] = ((a_q ^ b_q) == '0);
          end
          OP_NOT: begin
            result_d         = ~a_q;
            fr_out_d[FLAG_Z] = (~a_q == '0);
          end
          OP_SHF: begin
            unique case (sm_q)
              3'b000, 3'b001: result_d = a_q << n;
              3'b010, 3'b011: result_d = a_q >> n;
              3'b100, 3'b101: result_d = rotl;
              3'b110, 3'b111: result_d = rotr;
              default:        result_d = a_q;
            endcase
          end
          default: ;
        endcase
      end
      StDiv: begin
        if (div_valid) begin
          result_d          = (op_q == OP_DIV) ? div_quo : div_rem;
          fr_out_d          = fr_q;
          fr_out_d[FLAG_DZ] = 1'b0;
          fr_out_d[FLAG_Z]  = (((op_q == OP_DIV) ? div_quo : div_rem) == '0);
          state_d           = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wire_clock or posedge wire_reset) begin
    if (wire_reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      uc_q     <= 1'b0;
      dec_q    <= 1'b0;
      sm_q     <= '0;
      fr_q     <= '0;
      result_q <= '0;
      fr_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      uc_q     <= uc_d;
      dec_q    <= dec_d;
      sm_q     <= sm_d;
      fr_q     <= fr_d;
      result_q <= result_d;
      fr_out_q <= fr_out_d;
    end
  end

  assign result = result_q;
  assign fr_out = fr_out_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param at WIDTH=32: vector table plus reset and back-to-back sequences.
module tb_alu_seq_param;

  logic        wire_clock = 1'b0;
  logic        wire_reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  op_code = '0;
  logic [31:0] a = '0, b = '0;
  logic        use_carry = 1'b0;
  logic [2:0]  shift_mode = '0;
  logic        dec = 1'b0;
  logic [15:0] fr_in = '0;
  logic [31:0] result;
  logic [15:0] fr_out;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  alu_seq_param #(.WIDTH(32)) dut (
    .wire_clock (wire_clock),
    .wire_reset (wire_reset),
    .start      (start),
    .op_code    (op_code),
    .a          (a),
    .b          (b),
    .use_carry  (use_carry),
    .shift_mode (shift_mode),
    .dec        (dec),
    .fr_in      (fr_in),
    .result     (result),
    .fr_out     (fr_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 wire_clock = ~wire_clock;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        uc;
    logic [2:0]  sm;
    logic        dec;
    logic [15:0] fr;
    logic [31:0] res;
    logic [15:0] fro;
    int          lat;
  } vec_t;

  vec_t vecs[27];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns after the negedge where done is seen.
  task automatic run_op(input vec_t v, output int lat, output logic busy1);
    op_code = v.op; a = v.a; b = v.b; use_carry = v.uc;
    shift_mode = v.sm; dec = v.dec; fr_in = v.fr;
    start = 1'b1;
    @(posedge wire_clock);
    #1 start = 1'b0;
    a = ~v.a; b = ~v.b; fr_in = ~v.fr;  // must not disturb the op in flight
    lat = 0;
    busy1 = 1'b0;
    do begin
      @(negedge wire_clock);
      lat++;
      if (lat == 1) busy1 = busy;
    end while (!done && lat < 200);
  endtask

  initial begin
    int   lat;
    logic busy1;
    int   dcnt;
    int   dpos[$];

    vecs[0]  = '{6'b100000, 32'hFFFF_FFFF, 32'h1, 1'b0, 3'b000, 1'b0, 16'h0000, 32'h0, 16'h1800, 2};
    vecs[1]  = '{6'b011101, 32'h5, 32'h7, 1'b1, 3'b000, 1'b0, 16'h0800, 32'hD, 16'h0000, 2};
    vecs[2]  = '{6'b100001, 32'd10, 32'd3, 1'b0, 3'b000, 1'b0, 16'h0040, 32'h7, 16'h0000, 2};
    vecs[3]  = '{6'b100001, 32'd3, 32'd10, 1'b0, 3'b000, 1'b0, 16'h0000, 32'h0, 16'h1040, 2};
    vecs[4]  = '{6'b100001, 32'd5, 32'd6, 1'b1, 3'b000, 1'b0, 16'h0800, 32'h0, 16'h1800, 2};
    vecs[5]  = '{6'b100010, 32'h1_0000, 32'h1_0000, 1'b0, 3'b000, 1'b0, 16'h0000, 32'h0, 16'h1400, 2};
    vecs[6]  = '{6'b100010, 32'd6, 32'd7, 1'b0, 3'b000, 1'b0, 16'h1400, 32'd42, 16'h0000, 2};
    vecs[7]  = '{6'b100011, 32'd100, 32'd7, 1'b0, 3'b000, 1'b0, 16'h0200, 32'd14, 16'h0000, 34};
    vecs[8]  = '{6'b100101, 32'd100, 32'd7, 1'b0, 3'b000, 1'b0, 16'h0000, 32'd2, 16'h0000, 34};
    vecs[9]  = '{6'b100011, 32'd55, 32'd0, 1'b0, 3'b000, 1'b0, 16'h0000, 32'd2, 16'h0200, 2};
    vecs[10] = '{6'b100100, 32'hFFFF_FFFF, 32'h0, 1'b0, 3'b000, 1'b0, 16'h1234, 32'h0, 16'h1234, 2};
    vecs[11] = '{6'b100100, 32'h0, 32'h0, 1'b0, 3'b000, 1'b1, 16'h0000, 32'hFFFF_FFFF, 16'h0000, 2};
    vecs[12] = '{6'b010110, 32'd5, 32'd3, 1'b0, 3'b000, 1'b0, 16'h0000, 32'hFFFF_FFFF, 16'h8000, 2};
    vecs[13] = '{6'b010110, 32'd3, 32'd5, 1'b0, 3'b000, 1'b0, 16'hE000, 32'hFFFF_FFFF, 16'h4000, 2};
    vecs[14] = '{6'b010110, 32'd4, 32'd4, 1'b0, 3'b000, 1'b0, 16'h1FFF, 32'hFFFF_FFFF, 16'h3FFF, 2};
    vecs[15] = '{6'b010010, 32'hF0, 32'h0F, 1'b0, 3'b000, 1'b0, 16'h0000, 32'h0, 16'h1000, 2};
    vecs[16] = '{6'b010011, 32'hF0, 32'h0F, 1'b0, 3'b000, 1'b0, 16'h1000, 32'hFF, 16'h0000, 2};
    vecs[17] = '{6'b010100, 32'hFF, 32'h0F, 1'b0, 3'b000, 1'b0, 16'h0000, 32'hF0, 16'h0000, 2};
    vecs[18] = '{6'b010101, 32'hFFFF_FFFF, 32'h0, 1'b0, 3'b000, 1'b0, 16'h0000, 32'h0, 16'h1000, 2};
    vecs[19] = '{6'b010000, 32'h1, 32'd4, 1'b0, 3'b000, 1'b0, 16'h1000, 32'h10, 16'h1000, 2};
    vecs[20] = '{6'b010000, 32'h80, 32'd3, 1'b0, 3'b011, 1'b0, 16'h0000, 32'h10, 16'h0000, 2};
    vecs[21] = '{6'b010000, 32'h1, 32'd1, 1'b0, 3'b110, 1'b0, 16'h0000, 32'h8000_0000, 16'h0000, 2};
    vecs[22] = '{6'b010000, 32'h8000_0000, 32'd4, 1'b0, 3'b101, 1'b0, 16'h0000, 32'h8, 16'h0000, 2};
    vecs[23] = '{6'b010000, 32'h1234_5678, 32'h20, 1'b0, 3'b100, 1'b0, 16'h0000, 32'h1234_5678,
                 16'h0000, 2};
    vecs[24] = '{6'b000110, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 16'hABCD, 32'h1234_5678, 16'hABCD, 2};
    vecs[25] = '{6'b100011, 32'h1234_5678, 32'h10, 1'b0, 3'b000, 1'b0, 16'h1000, 32'h0123_4567,
                 16'h0000, 34};
    vecs[26] = '{6'b111111, 32'h5, 32'h6, 1'b0, 3'b000, 1'b0, 16'h0F0F, 32'h0123_4567, 16'h0F0F, 2};

    #1;
    chk("reset result", 64'(result), 64'h0);
    chk("reset fr_out", 64'(fr_out), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    repeat (3) @(negedge wire_clock);
    wire_reset = 1'b0;
    @(negedge wire_clock);

    for (int i = 0; i < 27; i++) begin
      run_op(vecs[i], lat, busy1);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d busy", i), 64'(busy1), 64'h1);
      chk($sformatf("v%0d result", i), 64'(result), 64'(vecs[i].res));
      chk($sformatf("v%0d fr_out", i), 64'(fr_out), 64'(vecs[i].fro));
      @(negedge wire_clock);
      chk($sformatf("v%0d done pulse width", i), 64'({busy, done}), 64'h0);
    end

    // Abandon a divide with an asynchronous reset mid-flight.
    op_code = 6'b100011; a = 32'd1000; b = 32'd3; fr_in = 16'h0; start = 1'b1;
    @(posedge wire_clock);
    #1 start = 1'b0;
    repeat (10) @(negedge wire_clock);
    #2 wire_reset = 1'b1;
    #1;
    chk("async reset result", 64'(result), 64'h0);
    chk("async reset fr_out", 64'(fr_out), 64'h0);
    chk("async reset busy", 64'(busy), 64'h0);
    repeat (2) @(negedge wire_clock);
    wire_reset = 1'b0;
    dcnt = 0;
    repeat (60) begin
      @(negedge wire_clock);
      if (done) dcnt++;
    end
    chk("no done after reset", 64'(dcnt), 64'h0);
    run_op('{6'b100000, 32'd2, 32'd3, 1'b0, 3'b000, 1'b0, 16'h0000, 32'd5, 16'h0000, 2},
           lat, busy1);
    chk("post-reset add latency", 64'(lat), 64'd2);
    chk("post-reset add result", 64'(result), 64'd5);
    @(negedge wire_clock);

    // start held high: accepts only in IDLE, one done every 3 cycles.
    op_code = 6'b010010; a = 32'hF0; b = 32'h0F; fr_in = 16'h1000; start = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge wire_clock);
      if (done) begin
        dpos.push_back(i);
        chk($sformatf("b2b result %0d", i), 64'(result), 64'h0);
        chk($sformatf("b2b fr_out %0d", i), 64'(fr_out), 64'h1000);
      end
    end
    start = 1'b0;
    repeat (5) begin
      @(negedge wire_clock);
      if (done) dpos.push_back(99);
    end
    chk("b2b done count", 64'(dpos.size()), 64'd3);
    if (dpos.size() == 3) begin
      chk("b2b first done", 64'(dpos[0]), 64'd2);
      chk("b2b spacing 1", 64'(dpos[1] - dpos[0]), 64'd3);
      chk("b2b spacing 2", 64'(dpos[2] - dpos[1]), 64'd3);
    end
    run_op('{6'b010010, 32'hF0, 32'hFF, 1'b0, 3'b000, 1'b0, 16'h1000, 32'hF0, 16'h0000, 2},
           lat, busy1);
    chk("and clears zero result", 64'(result), 64'hF0);
    chk("and clears zero fr_out", 64'(fr_out), 64'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
